float_unit_arbiter: RTL and testbench

Shares one pipelined float unit (adder, multiplier or similar) among NUM_REQ requesters. The unit has a fixed latency and advances on a clock enable.
- Arbitration is round-robin; one operand pair is issued per enabled cycle.
- A valid/tag token travels alongside the unit's pipeline, so each result is routed back to the requester that issued it.
- Output backpressure stalls the entire pipeline through the unit's ce.

---
 rtl/float_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/float_unit_arbiter.sv | 107 ++++++++++
 tb/tb_float_unit_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/float_arb_pkg.sv
// Shared constants and helpers for the float unit arbiter.
package float_arb_pkg;

    localparam int STAT_ISSUE_W = 16;
    localparam int STAT_STALL_W = 32;

    // Tag width: ceil(log2(n)), never below 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from a registered priority pointer.
// Zero latency; the pointer moves past the winner only when advance is high.
module rr_arbiter
    import float_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         grant_valid,
    output logic [W-1:0] grant
);

    logic [W-1:0] r_ptr;
    int           w_idx;

    // Walk from lowest to highest priority so the last hit (r_ptr itself) wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        w_idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (req[W'(w_idx)]) begin
                grant_valid = 1'b1;
                grant       = W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && grant_valid) begin
            r_ptr <= (grant == W'(N - 1)) ? '0 : grant + W'(1);
        end
    end

endmodule

// File: rtl/float_unit_arbiter.sv
// Round-robin sharing of one pipelined float unit; a {valid,tag} token rides beside the unit's data.
// Latency LATENCY ce-cycles issue-to-response; a refused response drops unit_ce, freezing the unit and issue.
// Optional FLOAT_ARB_STATS_EN adds saturating per-requester issue counters and a stall-cycle counter.
module float_unit_arbiter
    import float_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int OPERAND_SIZE = 32,
    parameter int RESULT_SIZE  = 32,
    parameter int LATENCY      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0] req_a,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0] req_b,
    output logic                            unit_ce,
    output logic [OPERAND_SIZE-1:0]         unit_a,
    output logic [OPERAND_SIZE-1:0]         unit_b,
    input  logic [RESULT_SIZE-1:0]          unit_result,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [RESULT_SIZE-1:0]          rsp_result
`ifdef FLOAT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_ISSUE_W-1:0] stat_issue_cnt,
    output logic [STAT_STALL_W-1:0]         stat_stall_cnt
`endif
);

    localparam int TAG_W = clog2(NUM_REQ);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } tok_t;

    tok_t             r_tok [LATENCY];
    tok_t             w_out;
    logic             w_gnt_vld;
    logic [TAG_W-1:0] w_gnt;
    logic             w_stall;
    logic             w_issue;

    assign w_out   = r_tok[LATENCY-1];
    assign w_stall = ~reset & w_out.vld & ~rsp_ready[w_out.tag];
    assign unit_ce = ~w_stall;
    assign w_issue = unit_ce & w_gnt_vld & ~reset;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .advance     (unit_ce),
        .grant_valid (w_gnt_vld),
        .grant       (w_gnt)
    );

    // With no grant w_gnt is 0, so requester 0's operands flow through under an invalid token.
    assign unit_a     = req_a[int'(w_gnt)*OPERAND_SIZE +: OPERAND_SIZE];
    assign unit_b     = req_b[int'(w_gnt)*OPERAND_SIZE +: OPERAND_SIZE];
    assign rsp_result = unit_result;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_issue & req_valid[i] & (w_gnt == TAG_W'(i));
            rsp_valid[i] = ~reset & w_out.vld & (w_out.tag == TAG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < LATENCY; s++) r_tok[s].vld <= 1'b0;
        end else if (unit_ce) begin
            r_tok[0] <= tok_t'{vld: w_issue, tag: w_gnt};
            for (int s = 1; s < LATENCY; s++) r_tok[s] <= r_tok[s-1];
        end
    end

`ifdef FLOAT_ARB_STATS_EN
    logic [STAT_ISSUE_W-1:0] r_issue_cnt [NUM_REQ];
    logic [STAT_STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_issue_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (r_issue_cnt[i] != '1)) r_issue_cnt[i] <= r_issue_cnt[i] + 1'b1;
            end
            if (!unit_ce && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        stat_issue_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_issue_cnt[i*STAT_ISSUE_W +: STAT_ISSUE_W] = r_issue_cnt[i];
    end

    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Directed bench for float_unit_arbiter with a 4-stage FP adder model on the unit side.
module tb_float_unit_arbiter;

    localparam logic [31:0] F05 = 32'h3F000000;
    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F7  = 32'h40E00000;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         unit_ce;
    logic [31:0]  unit_a;
    logic [31:0]  unit_b;
    logic [31:0]  unit_result;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_result;
`ifdef FLOAT_ARB_STATS_EN
    logic [63:0]  stat_issue_cnt;
    logic [31:0]  stat_stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    float_unit_arbiter #(
        .NUM_REQ(4), .OPERAND_SIZE(32), .RESULT_SIZE(32), .LATENCY(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .unit_ce     (unit_ce),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_result (unit_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result)
`ifdef FLOAT_ARB_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision add via double; exact for the small values used here.
    function automatic logic [63:0] s2d(input logic [31:0] x);
        logic [10:0] e;
        e = {3'b000, x[30:23]} + 11'd896;
        return {x[31], e, x[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real         r;
        logic [63:0] d;
        logic [10:0] e;
        r = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b));
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] pipe [4];
    always @(posedge clk) begin
        if (unit_ce) begin
            pipe[0] <= fadd(unit_a, unit_b);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end
    end
    assign unit_result = pipe[3];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // One cycle: drive, check combinational outputs mid-cycle, then advance past the edge.
    task automatic cyc(input logic [3:0] rv, input logic [3:0] rr, input logic exp_ce,
                       input logic [3:0] exp_rdy, input logic [3:0] exp_vld,
                       input logic [31:0] exp_res, input string tag);
        req_valid = rv;
        rsp_ready = rr;
        #1;
        chk({tag, ".ce"},  unit_ce,   exp_ce);
        chk({tag, ".rdy"}, req_ready, exp_rdy);
        chk({tag, ".vld"}, rsp_valid, exp_vld);
        if (exp_vld != 4'h0) chk({tag, ".res"}, rsp_result, exp_res);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        #1;
        chk({tag, ".rdy"}, req_ready, 4'h0);
        chk({tag, ".vld"}, rsp_valid, 4'h0);
        chk({tag, ".ce"},  unit_ce,   1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] sums [4];

    initial begin
        sums      = '{F2, F3, F4, F5};
        reset     = 1'b1;
        req_valid = 4'h0;
        rsp_ready = 4'hF;
        req_a     = {4{F1}};
        req_b     = {4{F1}};
        do_reset("rst0");

        // Ramp: requester 2 back-to-back, results 4 cycles later.
        set_op(2, F1, F2);   cyc(4'b0100, 4'hF, 1'b1, 4'b0100, 4'h0, 32'h0, "ramp0");
        set_op(2, F3, F4);   cyc(4'b0100, 4'hF, 1'b1, 4'b0100, 4'h0, 32'h0, "ramp1");
        set_op(2, F05, F05); cyc(4'b0100, 4'hF, 1'b1, 4'b0100, 4'h0, 32'h0, "ramp2");
        cyc(4'h0, 4'hF, 1'b1, 4'h0, 4'h0,    32'h0, "ramp3");
        cyc(4'h0, 4'hF, 1'b1, 4'h0, 4'b0100, F3,    "ramp4");
        cyc(4'h0, 4'hF, 1'b1, 4'h0, 4'b0100, F7,    "ramp5");
        cyc(4'h0, 4'hF, 1'b1, 4'h0, 4'b0100, F1,    "ramp6");
        cyc(4'h0, 4'hF, 1'b1, 4'h0, 4'h0,    32'h0, "ramp7");

        // Fairness: all four requesting for 8 cycles; requester i computes (i+1)+1.
        do_reset("rst1");
        set_op(0, F1, F1); set_op(1, F2, F1); set_op(2, F3, F1); set_op(3, F4, F1);
        for (int k = 0; k < 13; k++) begin
            cyc((k < 8) ? 4'hF : 4'h0, 4'hF, 1'b1,
                (k < 8) ? 4'(1 << (k % 4)) : 4'h0,
                (k >= 4 && k < 12) ? 4'(1 << (k % 4)) : 4'h0,
                sums[k % 4], $sformatf("fair%0d", k));
        end

        // Backpressure: requester 1's result held 3 cycles while requester 3 waits.
        cyc(4'b0010, 4'hF, 1'b1, 4'b0010, 4'h0, 32'h0, "bp0");
        cyc(4'b0100, 4'hF, 1'b1, 4'b0100, 4'h0, 32'h0, "bp1");
        cyc(4'b0001, 4'hF, 1'b1, 4'b0001, 4'h0, 32'h0, "bp2");
        cyc(4'b0000, 4'hF, 1'b1, 4'b0000, 4'h0, 32'h0, "bp3");
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1000, 4'b1101, 1'b0, 4'h0, 4'b0010, F3, $sformatf("bp_stall%0d", k));
        end
        cyc(4'b1000, 4'hF, 1'b1, 4'b1000, 4'b0010, F3,    "bp_rel");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0100, F4,    "bp8");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0001, F2,    "bp9");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bp10");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b1000, F5,    "bp11");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bp12");

`ifdef FLOAT_ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stat_issue%0d", i), stat_issue_cnt[i*16 +: 16], 64'd3);
        end
        chk("stat_stall", stat_stall_cnt, 64'd3);
`endif

        // Reset mid-flight: three tokens discarded, then 0 wins over 3.
        cyc(4'b0001, 4'hF, 1'b1, 4'b0001, 4'h0, 32'h0, "mid0");
        cyc(4'b0010, 4'hF, 1'b1, 4'b0010, 4'h0, 32'h0, "mid1");
        cyc(4'b0100, 4'hF, 1'b1, 4'b0100, 4'h0, 32'h0, "mid2");
        do_reset("mid_rst");
        cyc(4'b1001, 4'hF, 1'b1, 4'b0001, 4'h0,    32'h0, "mid4");
        cyc(4'b1001, 4'hF, 1'b1, 4'b1000, 4'h0,    32'h0, "mid5");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "mid6");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "mid7");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0001, F2,    "mid8");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b1000, F5,    "mid9");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "mid10");

        // Bubbles and pointer: single issue from 1 leaves ptr=2, so 2 beats 1.
        cyc(4'b0010, 4'hF, 1'b1, 4'b0010, 4'h0,    32'h0, "bub0");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub1");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub2");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub3");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0010, F3,    "bub4");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub5");
        cyc(4'b0110, 4'hF, 1'b1, 4'b0100, 4'h0,    32'h0, "bub6");
        cyc(4'b0010, 4'hF, 1'b1, 4'b0010, 4'h0,    32'h0, "bub7");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub8");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub9");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0100, F4,    "bub10");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'b0010, F3,    "bub11");
        cyc(4'b0000, 4'hF, 1'b1, 4'h0,    4'h0,    32'h0, "bub12");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
